// File: rtl/debounce_pkg.sv
// Shared constants, state encoding and counter-width helper for the input debouncer.
package debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int SYNC_STAGES             = 2;

  // The stable level doubles as the state encoding.
  typedef enum logic {
    IDLE_LOW  = 1'b0,
    IDLE_HIGH = 1'b1
  } deb_state_t;

  function automatic int cnt_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-FF synchroniser, qualification counter and stable register.
// Optional registered rising-edge pulse when PULSE_OUT_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
`ifdef PULSE_OUT_EN
  ,
  output logic rise
`endif
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE_LOW;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaults assigned first so no path through this block can infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    if (sync_out != logic'(state_q)) begin
      if (cnt_q == CNT_LAST) begin
        state_d = deb_state_t'(sync_out);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = (state_q == IDLE_HIGH);

`ifdef PULSE_OUT_EN
  logic stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= 1'b0;
      rise     <= 1'b0;
    end else begin
      stable_d <= level;
      rise     <= level & ~stable_d;
    end
  end
`endif

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce lanes conditioning the AND-gate lab inputs.
// Optional rising-edge pulse outputs A_rise/B_rise when PULSE_OUT_EN is defined.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic A_raw,
  input  logic B_raw,
  output logic A,
  output logic B
`ifdef PULSE_OUT_EN
  ,
  output logic A_rise,
  output logic B_rise
`endif
);

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (A_raw),
    .level (A)
`ifdef PULSE_OUT_EN
    ,
    .rise  (A_rise)
`endif
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (B_raw),
    .level (B)
`ifdef PULSE_OUT_EN
    ,
    .rise  (B_rise)
`endif
  );

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the two-input AND gate lab block.
- Takes two raw, asynchronous push-button/switch levels (A_raw, B_raw), synchronises each to clk and debounces it.
- Presents clean, glitch-free A and B levels that drive the gate inputs directly.
- Both channels are identical and independent; one instance serves both gate inputs.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronised input must hold its new level before the output follows. Legal range is 1 or more.
- CNT_W, derived (clog2(DEBOUNCE_CYCLES), minimum 1), counter width. Local constant, not overridable.

Ports:
- clk    input   1  system clock, all logic rising-edge.
- rst    input   1  reset, synchronous, active-high.
- A_raw  input   1  raw asynchronous level, channel A.
- B_raw  input   1  raw asynchronous level, channel B.
- A      output  1  debounced level, channel A; feeds gate input A.
- B      output  1  debounced level, channel B; feeds gate input B.
- A_rise output  1  present only with PULSE_OUT_EN.
- B_rise output  1  present only with PULSE_OUT_EN.

Behaviour:
- Single clock domain; one clock; reset is synchronous and active-high.
- Per channel, all state is registered: sync1, sync2 (2-FF synchroniser), cnt[CNT_W-1:0], stable.
- Outputs: A = stable_A, B = stable_B. Both are registered, with no combinational path from the raw inputs.
- Reset: while rst=1 at a rising edge, sync1, sync2, cnt and stable clear to 0. A, B (and A_rise, B_rise) read 0 from that edge on.
- The synchroniser shifts every edge: sync1 <= raw; sync2 <= sync1.
- Two-state view per channel, encoded by stable: IDLE_LOW (stable=0) and IDLE_HIGH (stable=1). The qualifying sub-condition is sync2 != stable.
- Each edge, when not in reset:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0. This is the state transition.
  - Else: cnt <= cnt + 1.
- Latency: number the edges, with edge 1 as the first edge that samples a new raw level. If raw holds, the output changes after edge DEBOUNCE_CYCLES+2.
  - DEBOUNCE_CYCLES=4 gives 6 cycles.
  - DEBOUNCE_CYCLES=1 gives 3 cycles.
- Glitch rejection: if sync2 returns to stable before the count completes, cnt clears and the output never changes. A pulse of fewer than DEBOUNCE_CYCLES cycles at sync2 is always rejected.
- Bouncing input: every return to the stable level restarts qualification from 0. There is no accumulation across bounces.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Channels A and B are fully independent. Simultaneous transitions on both resolve on the same edge if both are identical in timing.
- Reset mid-qualification discards the count. After reset deasserts, a held-high raw input needs the full DEBOUNCE_CYCLES+2 latency again.
- The block has no handshake and no backpressure. Outputs are levels.

Optional Feature:
- Macro: PULSE_OUT_EN.
- Defined: adds ports A_rise and B_rise.
  - Each is a registered one-cycle pulse, high on exactly the cycle after stable transitions 0 to 1.
  - Equivalent to stable & ~stable_d, using an extra registered stable_d.
  - Falling transitions produce no pulse.
  - Reset clears stable_d, and the pulses are 0.
- Undefined: the ports and stable_d are absent. A and B are unchanged.

Decomposition:
- Shared package/header debounce_pkg:
  - DEFAULT_DEBOUNCE_CYCLES = 4.
  - SYNC_STAGES = 2.
  - A clog2-based width function/macro for CNT_W.
- Sub-module debounce_channel, one per input: synchroniser, counter, stable register, optional pulse.
- input_debouncer instantiates two debounce_channel instances and wires the ports.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with A_raw=B_raw=1 -> A=B=0 throughout; after release, A rises exactly 6 cycles after the first sampling edge (N=4).
2. Clean press: A_raw 0->1, held for 20 cycles, N=4 -> A=1 after edge 6, stays 1; B stays 0.
3. Glitch: A_raw high for 3 cycles then low, N=4 -> A remains 0, cnt returns to 0.
4. Bounce then settle: A_raw toggles 1,0,1,0 per cycle then holds 1 -> A rises 6 cycles after the final 0->1 sampling edge.
5. Reset mid-count: A_raw=1, rst pulsed high at edge 4 -> A=0; A rises 6 cycles after the first post-reset sampling edge.
6. PULSE_OUT_EN with simultaneous press: A_raw=B_raw 0->1 -> A=B=1 after edge 6; A_rise=B_rise=1 for exactly one cycle (after edge 7), with no pulse on release.
